tdm_tx_master: RTL and testbench

//   TDM serial transmitter and bus master. Generates tdm_bclk_o and tdm_fsync_o, and serializes one parallel

---
 rtl/tdm_pkg.sv | 27 ++
 rtl/tdm_frame_timer.sv | 85 ++++++++
 rtl/tdm_tx_master.sv | 109 ++++++++++
 tb/tb_tdm_tx_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM master pair (tdm_tx_master / tdm_rx_master):
// counter sizing, slot-width legality and frame-sync trigger placement.
package tdm_pkg;

  // Single-cycle strobes published by the frame timer.
  typedef struct packed {
    logic rise;      // bclk rising event
    logic boundary;  // rising event that wraps (ch, dat) to (0, 0)
  } tdm_strobe_t;

  // fsync is raised on the rise event leaving this channel (counted back from the last slot).
  localparam int FSYNC_TRIG_CH_FROM_END = 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_legal_data_size(input int n);
    return (n == 16) || (n == 20) || (n == 24) || (n == 32);
  endfunction

  // Bit index (pre-increment) on which fsync is set so it leads ch0 MSB by tx_offset periods.
  function automatic int fsync_trig_dat(input int data_size, input int tx_offset);
    return data_size - tx_offset - 1;
  endfunction

endpackage

// File: rtl/tdm_frame_timer.sv
// Bit-clock divider plus slot/bit counters; produces bclk, fsync and the rise/boundary
// strobes. The counter values after a rise event are exported for bit selection.
module tdm_frame_timer
  import tdm_pkg::*;
#(
  parameter  int ClkDiv    = 2,
  parameter  int DataSize  = 32,
  parameter  int NChannels = 8,
  parameter  int TxOffset  = 1,
  localparam int ClkW      = cnt_width(ClkDiv),
  localparam int DatW      = cnt_width(DataSize),
  localparam int ChW       = cnt_width(NChannels)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            bclk_o,
  output logic            fsync_o,
  output tdm_strobe_t     strobe_o,
  output logic [DatW-1:0] dat_next_o,
  output logic [ChW-1:0]  ch_next_o
);

  localparam logic [ClkW-1:0] CLK_LAST = ClkW'(ClkDiv - 1);
  localparam logic [ClkW-1:0] CLK_FALL = ClkW'(ClkDiv / 2 - 1);
  localparam logic [DatW-1:0] DAT_LAST = DatW'(DataSize - 1);
  localparam logic [ChW-1:0]  CH_LAST  = ChW'(NChannels - 1);
  localparam logic [DatW-1:0] DAT_TRIG = DatW'(fsync_trig_dat(DataSize, TxOffset));
  localparam logic [ChW-1:0]  CH_TRIG  = ChW'(NChannels - FSYNC_TRIG_CH_FROM_END);

  logic [ClkW-1:0] clk_q, clk_d;
  logic [DatW-1:0] dat_q, dat_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic            bclk_q, bclk_d;
  logic            fsync_q, fsync_d;
  logic            rise, fall, boundary;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    rise     = (clk_q == CLK_LAST);
    fall     = (clk_q == CLK_FALL);
    boundary = rise && (ch_q == CH_LAST) && (dat_q == DAT_LAST);
    clk_d    = clk_q + ClkW'(1);
    bclk_d   = bclk_q;
    fsync_d  = fsync_q;
    dat_d    = dat_q;
    ch_d     = ch_q;
    if (rise) begin
      clk_d   = '0;
      bclk_d  = 1'b1;
      fsync_d = (ch_q == CH_TRIG) && (dat_q == DAT_TRIG);
      if (dat_q == DAT_LAST) begin
        dat_d = '0;
        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + ChW'(1);
      end else begin
        dat_d = dat_q + DatW'(1);
      end
    end else if (fall) begin
      bclk_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      clk_q   <= '0;
      dat_q   <= '0;
      ch_q    <= '0;
      bclk_q  <= 1'b0;
      fsync_q <= 1'b0;
    end else begin
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      ch_q    <= ch_d;
      bclk_q  <= bclk_d;
      fsync_q <= fsync_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fsync_o    = fsync_q;
  assign strobe_o   = '{rise: rise, boundary: boundary};
  assign dat_next_o = dat_d;
  assign ch_next_o  = ch_d;

endmodule

// File: rtl/tdm_tx_master.sv
// TDM transmit master: one-deep pending frame behind valid/ready, frame register
// swapped at each frame boundary, MSB-first bit selection and underrun flagging.
module tdm_tx_master
  import tdm_pkg::*;
#(
  parameter int ClkDiv    = 2,
  parameter int DataSize  = 32,
  parameter int NChannels = 8,
  parameter int TxOffset  = 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [DataSize*NChannels-1:0] tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_underrun_o,
  output logic                          tdm_bclk_o,
  output logic                          tdm_fsync_o,
  output logic                          tdm_data_o
);

  localparam int FrameW = DataSize * NChannels;
  localparam int IdxW   = cnt_width(FrameW);
  localparam int DatW   = cnt_width(DataSize);
  localparam int ChW    = cnt_width(NChannels);

  tdm_strobe_t     strobe;
  logic [DatW-1:0] dat_next;
  logic [ChW-1:0]  ch_next;

  tdm_frame_timer #(
    .ClkDiv   (ClkDiv),
    .DataSize (DataSize),
    .NChannels(NChannels),
    .TxOffset (TxOffset)
  ) u_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .bclk_o    (tdm_bclk_o),
    .fsync_o   (tdm_fsync_o),
    .strobe_o  (strobe),
    .dat_next_o(dat_next),
    .ch_next_o (ch_next)
  );

  logic [FrameW-1:0] frame_q, frame_d;
  logic [FrameW-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic              started_q, started_d;
  logic              underrun_q, underrun_d;
  logic              data_q, data_d;
  logic              handshake;
  logic [IdxW-1:0]   bit_idx;

  // Ready reflects only buffer state and reset, never tx_valid_i.
  assign tx_ready_o = ~pend_full_q & rstn_i;
  assign handshake  = tx_valid_i & tx_ready_o;

  always_comb begin
    frame_d     = frame_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    started_d   = started_q | handshake;
    underrun_d  = 1'b0;
    data_d      = data_q;
    if (strobe.boundary) begin
      if (pend_full_q) begin
        frame_d     = pend_q;
        pend_full_d = 1'b0;
      end else if (handshake) begin
        frame_d = tx_data_i;
      end else begin
        frame_d    = '0;
        underrun_d = started_q;
      end
    end else if (handshake) begin
      pend_d      = tx_data_i;
      pend_full_d = 1'b1;
    end
    // The new frame's ch0 MSB goes out on the same rise event that loads it.
    bit_idx = IdxW'(DataSize * int'(ch_next) + DataSize - 1 - int'(dat_next));
    if (strobe.rise) begin
      data_d = frame_d[bit_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // NOTE: the frame and pending data registers are reset too, so the post-reset frame is defined zeros.
      frame_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      started_q   <= 1'b0;
      underrun_q  <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      started_q   <= started_d;
      underrun_q  <= underrun_d;
      data_q      <= data_d;
    end
  end

  assign tx_underrun_o = underrun_q;
  assign tdm_data_o    = data_q;

endmodule

// File: tb/tb_tdm_tx_master.sv
// Bench for tdm_tx_master: reference model derives timing from cycle counts and frames from a queue.
module tb_tdm_tx_master;

  localparam int CD_A = 2, DS_A = 8, NC_A = 4, OFF_A = 2;
  localparam int FB_A = DS_A * NC_A, FC_A = CD_A * FB_A;
  localparam int CD_B = 3, DS_B = 24, NC_B = 4, OFF_B = 2;
  localparam int FB_B = DS_B * NC_B, FC_B = CD_B * FB_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn = 1'b0, tx_valid = 1'b0;
  logic [FB_A-1:0] tx_data = '0;
  logic            tx_ready, tx_underrun, bclk, fsync, sdata;

  logic            rstn_b = 1'b0, tx_valid_b = 1'b0;
  logic [FB_B-1:0] tx_data_b = '0;
  logic            tx_ready_b, tx_underrun_b, bclk_b, fsync_b, sdata_b;

  int tests = 0, fails = 0;

  tdm_tx_master #(.ClkDiv(CD_A), .DataSize(DS_A), .NChannels(NC_A), .TxOffset(OFF_A)) dut (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .tx_underrun_o(tx_underrun),
    .tdm_bclk_o(bclk), .tdm_fsync_o(fsync), .tdm_data_o(sdata)
  );

  tdm_tx_master #(.ClkDiv(CD_B), .DataSize(DS_B), .NChannels(NC_B), .TxOffset(OFF_B)) dut_b (
    .clk_i(clk), .rstn_i(rstn_b), .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b),
    .tx_ready_o(tx_ready_b), .tx_underrun_o(tx_underrun_b),
    .tdm_bclk_o(bclk_b), .tdm_fsync_o(fsync_b), .tdm_data_o(sdata_b)
  );

  // Reference model: n_* = clock edges since reset release; accepted frames wait in a queue.
  int              n_a = 0, n_b = 0;
  logic [FB_A-1:0] frame_m = '0;
  logic [FB_A-1:0] q_m[$];
  bit              started_m = 0, underrun_m = 0, acc_m = 0;

  function automatic bit bnd_next(int n);
    return ((n + 1) % CD_A == 0) && (((n + 1) / CD_A) % FB_A == 0);
  endfunction

  always @(posedge clk) begin
    bit hs;
    if (!rstn) begin
      n_a = 0; frame_m = '0; q_m.delete(); started_m = 0; underrun_m = 0; acc_m = 0;
    end else begin
      hs         = tx_valid && (q_m.size() == 0);
      acc_m      = hs;
      underrun_m = 0;
      if (hs) q_m.push_back(tx_data);
      if (bnd_next(n_a)) begin
        if (q_m.size() > 0) frame_m = q_m.pop_front();
        else begin frame_m = '0; underrun_m = started_m; end
      end
      if (hs) started_m = 1;
      n_a++;
    end
    if (!rstn_b) n_b = 0; else n_b++;
  end

  function automatic logic f_bclk(int n, int cd);
    return (n >= cd) && ((n % cd) < (cd / 2));
  endfunction

  function automatic logic [4:0] exp_a();
    int s;
    s = (n_a / CD_A) % FB_A;
    return {f_bclk(n_a, CD_A), logic'(s == FB_A - OFF_A),
            frame_m[DS_A * (s / DS_A) + DS_A - 1 - (s % DS_A)],
            logic'(rstn && (q_m.size() == 0)), logic'(underrun_m)};
  endfunction

  function automatic logic [4:0] exp_b();
    int s;
    s = (n_b / CD_B) % FB_B;
    return {f_bclk(n_b, CD_B), logic'(s == FB_B - OFF_B), 1'b0, rstn_b, 1'b0};
  endfunction

  function automatic logic [4:0] obs_a();
    return {bclk, fsync, sdata, tx_ready, tx_underrun};
  endfunction

  function automatic logic [4:0] obs_b();
    return {bclk_b, fsync_b, sdata_b, tx_ready_b, tx_underrun_b};
  endfunction

  task automatic test_reset();
    int   fs_rises = 0;
    logic prev_fs  = 1'b0;
    rstn = 1'b0; rstn_b = 1'b0; tx_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({obs_a(), obs_b()} !== 10'b0) begin
        fails++; $display("FAIL reset_hold got=%b exp=0000000000", {obs_a(), obs_b()});
      end
    end
    rstn = 1'b1; rstn_b = 1'b1;
    repeat (2 * FC_A) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL reset_run_a n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++; $display("FAIL reset_run_b n=%0d got=%b exp=%b", n_b, obs_b(), exp_b());
      end
      if (fsync && !prev_fs) fs_rises++;
      prev_fs = fsync;
    end
    tests++;
    if (fs_rises !== 2) begin
      fails++; $display("FAIL reset_fsync_count got=%0d exp=2", fs_rises);
    end
  endtask

  task automatic test_single_frame();
    logic [FB_A-1:0] got    = '0;
    int              state  = 0, skip = 0, nbits = 0;
    logic            prev_b, fall;
    @(negedge clk); rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1; tx_valid = 1'b1; tx_data = 32'hA53C_0F81;
    prev_b = bclk;
    repeat (2 * FC_A - 1) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL single_frame n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      fall = prev_b && !bclk;
      case (state)
        0: if (fsync) begin state = 1; skip = OFF_A; end
        1: if (fall) begin skip--; if (skip == 0) state = 2; end
        default: if (fall && nbits < FB_A) begin
          got[DS_A * (nbits / DS_A) + DS_A - 1 - (nbits % DS_A)] = sdata;
          nbits++;
        end
      endcase
      prev_b = bclk;
    end
    tests++;
    if (nbits != FB_A || got !== 32'hA53C_0F81) begin
      fails++; $display("FAIL single_frame_deser bits=%0d got=%h exp=a53c0f81", nbits, got);
    end
  endtask

  task automatic test_underrun();
    int pulses = 0, width = 0, max_w = 0;
    for (int i = 0; i < 2 * FC_A; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL underrun_run n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      if (i == 0) begin
        tests++;
        if (tx_underrun !== 1'b1) begin
          fails++; $display("FAIL underrun_at_boundary got=%b exp=1", tx_underrun);
        end
      end
      if (tx_underrun) begin width++; if (width == 1) pulses++; end else width = 0;
      if (width > max_w) max_w = width;
      if (i == 1) begin tx_valid = 1'b1; tx_data = $urandom; end else tx_valid = 1'b0;
    end
    tests++;
    if (pulses != 1 || max_w != 1) begin
      fails++; $display("FAIL underrun_pulse pulses=%0d width=%0d exp=1/1", pulses, max_w);
    end
  endtask

  task automatic test_bypass();
    int budget = FC_A + 2;
    while (!bnd_next(n_a) && budget > 0) begin
      @(negedge clk);
      budget--;
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL bypass_wait n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
    end
    tests++;
    if (budget == 0 || tx_ready !== 1'b1) begin
      fails++; $display("FAIL bypass_pre budget=%0d ready=%b exp=1", budget, tx_ready);
    end
    tx_valid = 1'b1; tx_data = $urandom;
    @(negedge clk);
    tx_valid = 1'b0;
    tests++;
    if ({tx_ready, tx_underrun} !== 2'b10) begin
      fails++; $display("FAIL bypass_flags got=%b exp=10", {tx_ready, tx_underrun});
    end
    repeat (FC_A - 4) begin
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL bypass_run n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int budget = FC_A + 2, acc = 0, ur = 0;
    tx_valid = 1'b1; tx_data = $urandom;
    while ((n_a % FC_A) != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (acc_m) tx_data = $urandom;
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL b2b_align n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
    end
    for (int i = 0; i < 3 * FC_A; i++) begin
      if (tx_valid && tx_ready) acc++;
      @(negedge clk);
      if (acc_m) tx_data = $urandom;
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL b2b_run n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      if (tx_underrun) ur++;
    end
    tx_valid = 1'b0;
    tests++;
    if (budget == 0 || acc != 3 || ur != 0) begin
      fails++; $display("FAIL b2b_accepts acc=%0d underruns=%0d exp=3/0", acc, ur);
    end
  endtask

  task automatic test_mid_reset();
    int   budget = FC_A + 2, fs_rises = 0;
    logic prev_fs = 1'b0;
    while (((n_a / CD_A) % FB_A) != 2 * DS_A + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL mid_reset_wait n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if (budget == 0 || obs_a() !== 5'b0) begin
      fails++; $display("FAIL mid_reset_zero budget=%0d got=%b exp=00000", budget, obs_a());
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * FC_A) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== exp_a()) begin
        fails++; $display("FAIL mid_reset_run n=%0d got=%b exp=%b", n_a, obs_a(), exp_a());
      end
      if (fsync && !prev_fs) fs_rises++;
      prev_fs = fsync;
    end
    tests++;
    if (fs_rises != 2) begin
      fails++; $display("FAIL mid_reset_fsync_count got=%0d exp=2", fs_rises);
    end
  endtask

  task automatic test_mid_reset_b();
    int   budget = FC_B + 3, fs_rises = 0;
    logic prev_fs = 1'b0;
    while (((n_b / CD_B) % FB_B) != 2 * DS_B + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++; $display("FAIL mid_reset_b_wait n=%0d got=%b exp=%b", n_b, obs_b(), exp_b());
      end
    end
    rstn_b = 1'b0;
    @(negedge clk);
    tests++;
    if (budget == 0 || obs_b() !== 5'b0) begin
      fails++; $display("FAIL mid_reset_b_zero budget=%0d got=%b exp=00000", budget, obs_b());
    end
    repeat (2) @(negedge clk);
    rstn_b = 1'b1;
    repeat (FC_B) begin
      @(negedge clk);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++; $display("FAIL mid_reset_b_run n=%0d got=%b exp=%b", n_b, obs_b(), exp_b());
      end
      if (fsync_b && !prev_fs) fs_rises++;
      prev_fs = fsync_b;
    end
    tests++;
    if (fs_rises != 1) begin
      fails++; $display("FAIL mid_reset_b_fsync_count got=%0d exp=1", fs_rises);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    test_mid_reset_b();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
